// File: rtl/ro_buffer_wide.sv
// Reorder buffer: allocates entries in order, takes results from the CDB ports and
// forwards them to operand lookups, retires up to two entries per cycle and flushes on a mispredict.
module ro_buffer_wide #(
    parameter int DEPTH    = 16,
    parameter int ID_W     = 5,
    parameter int XLEN     = 32,
    parameter int NUM_CDB  = 2,
    parameter int COMMIT_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     alloc_valid,
    input  logic [1:0]               alloc_signal,
    input  logic [4:0]               alloc_rd,
    input  logic [XLEN-1:0]          alloc_next_pc,
    output logic [ID_W-1:0]          alloc_id,
    output logic                     full,
    input  logic [ID_W-1:0]          qj,
    input  logic [ID_W-1:0]          qk,
    output logic                     vj_valid,
    output logic [XLEN-1:0]          vj,
    output logic                     vk_valid,
    output logic [XLEN-1:0]          vk,
    input  logic [NUM_CDB*ID_W-1:0]  cdb_dest,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_value,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_next_pc,
    output logic [COMMIT_W*ID_W-1:0] commit_dest,
    output logic [COMMIT_W*5-1:0]    commit_rd,
    output logic [COMMIT_W*XLEN-1:0] commit_value,
    output logic [ID_W-1:0]          store_commit_dest,
    output logic                     flush,
    output logic [XLEN-1:0]          flush_pc
);

    localparam logic [1:0]      KIND_NORMAL = 2'd0;
    localparam logic [1:0]      KIND_BRANCH = 2'd1;
    localparam logic [1:0]      KIND_STORE  = 2'd2;
    localparam logic [ID_W-1:0] ID_NONE     = {ID_W{1'b0}};
    localparam logic [ID_W-1:0] ID_FIRST    = ID_W'(1);
    localparam logic [ID_W-1:0] ID_LAST     = ID_W'(DEPTH);
    localparam logic [XLEN-1:0] XZERO       = {XLEN{1'b0}};

    typedef struct packed {
        logic            busy;
        logic            ready;
        logic [1:0]      kind;
        logic [4:0]      rd;
        logic [XLEN-1:0] value;
        logic [XLEN-1:0] pred_pc;
        logic [XLEN-1:0] next_pc;
    } entry_t;

    localparam entry_t ENTRY_CLEAR = '0;

    // Index 0 is the "none" id and is never allocated.
    entry_t          entry_r [0:DEPTH];
    logic [ID_W-1:0] head_r;
    logic [ID_W-1:0] tail_r;
    logic [ID_W-1:0] count_r;

    logic [ID_W-1:0] slot_id_s [0:1];
    entry_t          slot_e_s  [0:1];
    logic [1:0]      ret_s;
    logic [1:0]      commit_slot_s;
    logic            mis0_s;
    logic            mis1_s;
    logic            flush_s;
    logic [XLEN-1:0] flush_target_s;
    logic [1:0]      n_ret_s;
    logic            alloc_acc_s;
    logic [ID_W-1:0] store_id_s;
    entry_t          alloc_entry_s;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        logic [ID_W-1:0] nxt;
        if (id == ID_LAST) begin
            nxt = ID_FIRST;
        end else begin
            nxt = id + ID_FIRST;
        end
        return nxt;
    endfunction

    function automatic logic id_in_range(input logic [ID_W-1:0] id);
        return (id != ID_NONE) && (id <= ID_LAST);
    endfunction

    function automatic logic mispredict(input entry_t e);
        return (e.kind == KIND_BRANCH) && (e.next_pc != e.pred_pc);
    endfunction

    // Returns {valid, value}; a same-cycle CDB hit overrides the stored value.
    function automatic logic [XLEN:0] lookup(input logic [ID_W-1:0] q);
        logic [XLEN:0] res;
        res = {1'b0, XZERO};
        if (id_in_range(q)) begin
            res = entry_r[q].ready ? {1'b1, entry_r[q].value} : {1'b0, XZERO};
            for (int p = 0; p < NUM_CDB; p++) begin
                res = (cdb_dest[p*ID_W +: ID_W] == q) ? {1'b1, cdb_value[p*XLEN +: XLEN]} : res;
            end
        end else begin
            res = {1'b0, XZERO};
        end
        return res;
    endfunction

    assign alloc_id = tail_r;
    assign full     = (count_r == ID_LAST);

    // Operand lookup for both issuer tags.
    always_comb begin
        {vj_valid, vj} = lookup(qj);
        {vk_valid, vk} = lookup(qk);
    end

    // Retire selection for the two head slots and mispredict detection.
    always_comb begin
        slot_id_s[0] = head_r;
        slot_id_s[1] = next_id(head_r);
        slot_e_s[0]  = entry_r[slot_id_s[0]];
        slot_e_s[1]  = entry_r[slot_id_s[1]];
        ret_s        = 2'b00;
        ret_s[0]     = (count_r != ID_NONE) && slot_e_s[0].ready;
        mis0_s       = ret_s[0] && mispredict(slot_e_s[0]);
        // Two stores cannot leave together: the store port takes one per cycle.
        if (COMMIT_W == 2) begin
            ret_s[1] = ret_s[0] && (count_r >= ID_W'(2)) && slot_e_s[1].ready
                       && !((slot_e_s[0].kind == KIND_STORE) && (slot_e_s[1].kind == KIND_STORE))
                       && !mis0_s;
        end else begin
            ret_s[1] = 1'b0;
        end
        mis1_s         = ret_s[1] && mispredict(slot_e_s[1]);
        flush_s        = mis0_s || mis1_s;
        flush_target_s = mis0_s ? slot_e_s[0].next_pc : slot_e_s[1].next_pc;
        n_ret_s        = {1'b0, ret_s[0]} + {1'b0, ret_s[1]};
        commit_slot_s[0] = ret_s[0] && (slot_e_s[0].kind == KIND_NORMAL);
        commit_slot_s[1] = ret_s[1] && (slot_e_s[1].kind == KIND_NORMAL);
        if (ret_s[0] && (slot_e_s[0].kind == KIND_STORE)) begin
            store_id_s = slot_id_s[0];
        end else if (ret_s[1] && (slot_e_s[1].kind == KIND_STORE)) begin
            store_id_s = slot_id_s[1];
        end else begin
            store_id_s = ID_NONE;
        end
    end

    // Allocation acceptance and the entry image written at the tail.
    always_comb begin
        alloc_acc_s           = alloc_valid && !full && !flush_s && !flush;
        alloc_entry_s         = ENTRY_CLEAR;
        alloc_entry_s.busy    = 1'b1;
        alloc_entry_s.ready   = 1'b0;
        alloc_entry_s.kind    = alloc_signal;
        alloc_entry_s.rd      = alloc_rd;
        alloc_entry_s.pred_pc = alloc_next_pc;
    end

    // Entry storage, head/tail pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= ID_FIRST;
            tail_r  <= ID_FIRST;
            count_r <= ID_NONE;
            for (int i = 0; i <= DEPTH; i++) begin
                entry_r[i] <= ENTRY_CLEAR;
            end
        end else if (rdy) begin
            if (flush_s) begin
                head_r  <= ID_FIRST;
                tail_r  <= ID_FIRST;
                count_r <= ID_NONE;
                for (int i = 0; i <= DEPTH; i++) begin
                    entry_r[i] <= ENTRY_CLEAR;
                end
            end else begin
                for (int p = 0; p < NUM_CDB; p++) begin
                    if (id_in_range(cdb_dest[p*ID_W +: ID_W]) && entry_r[cdb_dest[p*ID_W +: ID_W]].busy) begin
                        entry_r[cdb_dest[p*ID_W +: ID_W]].ready   <= 1'b1;
                        entry_r[cdb_dest[p*ID_W +: ID_W]].value   <= cdb_value[p*XLEN +: XLEN];
                        entry_r[cdb_dest[p*ID_W +: ID_W]].next_pc <= cdb_next_pc[p*XLEN +: XLEN];
                    end
                end
                for (int s = 0; s < 2; s++) begin
                    if (ret_s[s]) begin
                        entry_r[slot_id_s[s]] <= ENTRY_CLEAR;
                    end
                end
                if (alloc_acc_s) begin
                    entry_r[tail_r] <= alloc_entry_s;
                end
                head_r  <= ret_s[1] ? next_id(slot_id_s[1]) : (ret_s[0] ? slot_id_s[1] : head_r);
                tail_r  <= alloc_acc_s ? next_id(tail_r) : tail_r;
                count_r <= count_r + ID_W'(alloc_acc_s) - ID_W'(n_ret_s);
            end
        end
    end

    // Registered retirement, store and flush outputs; idle slots drop to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_dest       <= {(COMMIT_W*ID_W){1'b0}};
            commit_rd         <= {(COMMIT_W*5){1'b0}};
            commit_value      <= {(COMMIT_W*XLEN){1'b0}};
            store_commit_dest <= ID_NONE;
            flush             <= 1'b0;
            flush_pc          <= XZERO;
        end else if (rdy) begin
            for (int s = 0; s < COMMIT_W; s++) begin
                commit_dest[s*ID_W +: ID_W]  <= commit_slot_s[s] ? slot_id_s[s] : ID_NONE;
                commit_rd[s*5 +: 5]          <= commit_slot_s[s] ? slot_e_s[s].rd : 5'd0;
                commit_value[s*XLEN +: XLEN] <= commit_slot_s[s] ? slot_e_s[s].value : XZERO;
            end
            store_commit_dest <= store_id_s;
            flush             <= flush_s;
            flush_pc          <= flush_s ? flush_target_s : XZERO;
        end
    end

endmodule

// File: tb/tb_ro_buffer_wide.sv
// Directed bench for ro_buffer_wide: fill/full, dual retire, CDB bypass, mispredict flush,
// wrap-around, store serialisation, rdy hold and mid-stream reset.
module tb_ro_buffer_wide;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        alloc_valid;
    logic [1:0]  alloc_signal;
    logic [4:0]  alloc_rd;
    logic [31:0] alloc_next_pc;
    logic [4:0]  alloc_id;
    logic        full;
    logic [4:0]  qj;
    logic [4:0]  qk;
    logic        vj_valid;
    logic [31:0] vj;
    logic        vk_valid;
    logic [31:0] vk;
    logic [9:0]  cdb_dest;
    logic [63:0] cdb_value;
    logic [63:0] cdb_next_pc;
    logic [9:0]  commit_dest;
    logic [9:0]  commit_rd;
    logic [63:0] commit_value;
    logic [4:0]  store_commit_dest;
    logic        flush;
    logic [31:0] flush_pc;

    int n_assert = 0;
    int n_fail   = 0;

    ro_buffer_wide #(.DEPTH(16), .ID_W(5), .XLEN(32), .NUM_CDB(2), .COMMIT_W(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_signal(alloc_signal), .alloc_rd(alloc_rd),
        .alloc_next_pc(alloc_next_pc), .alloc_id(alloc_id), .full(full),
        .qj(qj), .qk(qk), .vj_valid(vj_valid), .vj(vj), .vk_valid(vk_valid), .vk(vk),
        .cdb_dest(cdb_dest), .cdb_value(cdb_value), .cdb_next_pc(cdb_next_pc),
        .commit_dest(commit_dest), .commit_rd(commit_rd), .commit_value(commit_value),
        .store_commit_dest(store_commit_dest), .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required $finish before 200000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cdb(input logic [4:0] d0, input logic [31:0] v0, input logic [31:0] p0,
                           input logic [4:0] d1, input logic [31:0] v1, input logic [31:0] p1);
        cdb_dest    = {d1, d0};
        cdb_value   = {v1, v0};
        cdb_next_pc = {p1, p0};
    endtask

    task automatic do_alloc(input logic [1:0] k, input logic [4:0] r, input logic [31:0] pc,
                            input logic [4:0] exp_id);
        alloc_valid   = 1'b1;
        alloc_signal  = k;
        alloc_rd      = r;
        alloc_next_pc = pc;
        #1;
        chk("alloc_id", {59'd0, alloc_id}, {59'd0, exp_id});
        tick();
        alloc_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; alloc_valid = 1'b0; alloc_signal = 2'd0; alloc_rd = 5'd0;
        alloc_next_pc = 32'd0; qj = 5'd0; qk = 5'd0;
        set_cdb(5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0);
        tick(); tick();
        chk("rst_alloc_id", {59'd0, alloc_id}, 64'd1);
        chk("rst_full", {63'd0, full}, 64'd0);
        chk("rst_commit_dest", {54'd0, commit_dest}, 64'd0);
        chk("rst_commit_rd", {54'd0, commit_rd}, 64'd0);
        chk("rst_commit_value", commit_value, 64'd0);
        chk("rst_store", {59'd0, store_commit_dest}, 64'd0);
        chk("rst_flush", {63'd0, flush}, 64'd0);
        chk("rst_flush_pc", {32'd0, flush_pc}, 64'd0);
        rst = 1'b0;

        // Fill all 16 entries, then one more request while full.
        for (int i = 1; i <= 16; i++) begin
            do_alloc(2'd0, 5'(i), 32'd0, 5'(i));
        end
        chk("fill_full", {63'd0, full}, 64'd1);
        chk("fill_tail_wrap", {59'd0, alloc_id}, 64'd1);
        alloc_valid = 1'b1;
        tick();
        alloc_valid = 1'b0;
        chk("overfill_full", {63'd0, full}, 64'd1);
        chk("overfill_alloc_id", {59'd0, alloc_id}, 64'd1);
        chk("overfill_no_commit", {54'd0, commit_dest}, 64'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst2_full", {63'd0, full}, 64'd0);

        // Dual retire of two NORMAL entries written back together.
        do_alloc(2'd0, 5'd5, 32'd0, 5'd1);
        do_alloc(2'd0, 5'd6, 32'd0, 5'd2);
        set_cdb(5'd1, 32'hA, 32'd0, 5'd2, 32'hB, 32'd0);
        tick();
        chk("wb_latency", {54'd0, commit_dest}, 64'd0);
        set_cdb(5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0);
        tick();
        chk("dual_dest", {54'd0, commit_dest}, 64'h41);
        chk("dual_rd", {54'd0, commit_rd}, 64'hC5);
        chk("dual_value", commit_value, 64'h0000000B_0000000A);
        tick();
        chk("idle_dest", {54'd0, commit_dest}, 64'd0);
        chk("idle_value", commit_value, 64'd0);

        // Operand bypass from CDB port 1, then the stored value.
        do_alloc(2'd0, 5'd7, 32'd0, 5'd3);
        qj = 5'd3;
        #1;
        chk("vj_not_ready", {63'd0, vj_valid}, 64'd0);
        set_cdb(5'd0, 32'd0, 32'd0, 5'd3, 32'h55, 32'd0);
        #1;
        chk("bypass_vj_valid", {63'd0, vj_valid}, 64'd1);
        chk("bypass_vj", {32'd0, vj}, 64'h55);
        chk("q0_vk_valid", {63'd0, vk_valid}, 64'd0);
        chk("q0_vk", {32'd0, vk}, 64'd0);
        tick();
        set_cdb(5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0);
        #1;
        chk("stored_vj_valid", {63'd0, vj_valid}, 64'd1);
        chk("stored_vj", {32'd0, vj}, 64'h55);
        qj = 5'd0;
        tick();
        chk("single_dest", {54'd0, commit_dest}, 64'd3);
        chk("single_rd", {54'd0, commit_rd}, 64'd7);
        chk("single_value", commit_value, 64'h55);

        // Mispredicted branch at id 4 with ready younger entries 5 and 6.
        do_alloc(2'd1, 5'd0, 32'h100, 5'd4);
        do_alloc(2'd0, 5'd8, 32'd0, 5'd5);
        do_alloc(2'd0, 5'd9, 32'd0, 5'd6);
        set_cdb(5'd5, 32'h11, 32'd0, 5'd6, 32'h22, 32'd0);
        tick();
        set_cdb(5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0);
        tick();
        chk("head_blocks", {54'd0, commit_dest}, 64'd0);
        set_cdb(5'd4, 32'd0, 32'h200, 5'd0, 32'd0, 32'd0);
        tick();
        set_cdb(5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0);
        alloc_valid = 1'b1; alloc_signal = 2'd0; alloc_rd = 5'd10;
        tick();
        chk("flush_pulse", {63'd0, flush}, 64'd1);
        chk("flush_pc", {32'd0, flush_pc}, 64'h200);
        chk("flush_no_commit", {54'd0, commit_dest}, 64'd0);
        chk("flush_alloc_id", {59'd0, alloc_id}, 64'd1);
        tick();
        alloc_valid = 1'b0;
        chk("flush_drop", {63'd0, flush}, 64'd0);
        chk("flush_pc_clear", {32'd0, flush_pc}, 64'd0);
        chk("flush_block_alloc", {59'd0, alloc_id}, 64'd1);
        chk("young_never_commit", {54'd0, commit_dest}, 64'd0);
        tick();
        chk("young_never_commit2", {54'd0, commit_dest}, 64'd0);

        // Wrap-around: fill, retire three, allocate ids 1 and 2, continue in order.
        for (int i = 1; i <= 16; i++) begin
            do_alloc(2'd0, 5'(i), 32'd0, 5'(i));
        end
        set_cdb(5'd1, 32'h101, 32'd0, 5'd2, 32'h102, 32'd0);
        tick();
        set_cdb(5'd3, 32'h103, 32'd0, 5'd0, 32'd0, 32'd0);
        tick();
        chk("wrap_dual_dest", {54'd0, commit_dest}, 64'h41);
        chk("wrap_dual_value", commit_value, 64'h00000102_00000101);
        set_cdb(5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0);
        tick();
        chk("wrap_third_dest", {54'd0, commit_dest}, 64'd3);
        chk("wrap_third_value", commit_value, 64'h103);
        do_alloc(2'd0, 5'd20, 32'd0, 5'd1);
        do_alloc(2'd0, 5'd21, 32'd0, 5'd2);
        chk("wrap_count15_full", {63'd0, full}, 64'd0);
        do_alloc(2'd0, 5'd22, 32'd0, 5'd3);
        chk("wrap_count16_full", {63'd0, full}, 64'd1);
        set_cdb(5'd1, 32'h201, 32'd0, 5'd4, 32'h104, 32'd0);
        tick();
        set_cdb(5'd5, 32'h105, 32'd0, 5'd0, 32'd0, 32'd0);
        tick();
        chk("order_dest4", {54'd0, commit_dest}, 64'd4);
        chk("order_rd4", {54'd0, commit_rd}, 64'd4);
        chk("order_value4", commit_value, 64'h104);
        set_cdb(5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0);
        tick();
        chk("order_dest5", {54'd0, commit_dest}, 64'd5);
        chk("order_value5", commit_value, 64'h105);
        rst = 1'b1; tick(); rst = 1'b0;

        // Back-to-back stores retire one per cycle; rdy low holds; reset mid-stream.
        do_alloc(2'd2, 5'd0, 32'd0, 5'd1);
        do_alloc(2'd2, 5'd0, 32'd0, 5'd2);
        do_alloc(2'd2, 5'd0, 32'd0, 5'd3);
        set_cdb(5'd1, 32'd0, 32'd0, 5'd2, 32'd0, 32'd0);
        tick();
        set_cdb(5'd3, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0);
        tick();
        chk("store1", {59'd0, store_commit_dest}, 64'd1);
        chk("store1_no_reg", {54'd0, commit_dest}, 64'd0);
        set_cdb(5'd0, 32'd0, 32'd0, 5'd0, 32'd0, 32'd0);
        rdy = 1'b0;
        tick();
        chk("rdy_hold_store", {59'd0, store_commit_dest}, 64'd1);
        rdy = 1'b1;
        tick();
        chk("store2", {59'd0, store_commit_dest}, 64'd2);
        rst = 1'b1;
        tick();
        chk("midrst_store", {59'd0, store_commit_dest}, 64'd0);
        chk("midrst_dest", {54'd0, commit_dest}, 64'd0);
        chk("midrst_flush", {63'd0, flush}, 64'd0);
        chk("midrst_alloc_id", {59'd0, alloc_id}, 64'd1);
        rst = 1'b0;
        tick();
        chk("store3_discarded", {59'd0, store_commit_dest}, 64'd0);
        do_alloc(2'd0, 5'd1, 32'd0, 5'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
